// File: rtl/s_proc_pkg.sv
// Shared definitions for the s_proc pipeline: default widths and fetch FSM encoding.
package s_proc_pkg;

   localparam int unsigned DefAdrsW  = 8;
   localparam int unsigned DefInstrW = 16;

   // Fetch FSM encoding: IDLE=0, REQ=1, HOLD=2, SYNC=3, ERR=4.
   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StReq  = 3'd1,
      StHold = 3'd2,
      StSync = 3'd3,
      StErr  = 3'd4
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: reads PC, fetches from instruction memory over req/ack, holds the
// word in an instruction register for the decoder and returns the next PC with a load strobe.
module fetch_unit
   import s_proc_pkg::*;
#(
   parameter int unsigned ADRS_W  = DefAdrsW,
   parameter int unsigned INSTR_W = DefInstrW,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               fetch_en,
   input  logic [ADRS_W-1:0]  pc_adrs,
   output logic [ADRS_W-1:0]  pc_next,
   output logic               en_pc,
   output logic               mem_req,
   output logic [ADRS_W-1:0]  mem_adrs,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic [INSTR_W-1:0] ir_out,
   output logic               ir_valid,
   input  logic               ir_ready,
   input  logic               branch_taken,
   input  logic [ADRS_W-1:0]  branch_target,
   output logic               fetch_err
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   fetch_state_e       state_q, state_d;
   logic [ADRS_W-1:0]  pc_next_q, pc_next_d;
   logic [ADRS_W-1:0]  mem_adrs_q, mem_adrs_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               mem_req_q, mem_req_d;
   logic               en_pc_q, en_pc_d;
   logic               ir_valid_q, ir_valid_d;
   logic               err_q, err_d;
   logic [CntW-1:0]    cnt_inc;

   assign cnt_inc = cnt_q + CntW'(1);

   // Next-state and registered-output logic for the fetch FSM.
   always_comb begin
      state_d    = state_q;
      pc_next_d  = pc_next_q;
      mem_adrs_d = mem_adrs_q;
      ir_d       = ir_q;
      cnt_d      = cnt_q;
      mem_req_d  = mem_req_q;
      en_pc_d    = 1'b0;
      ir_valid_d = ir_valid_q;
      err_d      = err_q;

      case (state_q)
         StIdle: begin
            if (fetch_en) begin
               state_d    = StReq;
               mem_adrs_d = pc_adrs;
               mem_req_d  = 1'b1;
               cnt_d      = '0;
            end
         end
         StReq: begin
            if (mem_ack) begin
               state_d    = StHold;
               ir_d       = mem_rdata;
               ir_valid_d = 1'b1;
               mem_req_d  = 1'b0;
            end else if (cnt_inc == CntW'(TIMEOUT)) begin
               // TIMEOUT consecutive REQ cycles without an ack.
               state_d   = StErr;
               err_d     = 1'b1;
               mem_req_d = 1'b0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StHold: begin
            if (ir_ready) begin
               state_d    = StSync;
               ir_valid_d = 1'b0;
               en_pc_d    = 1'b1;
               // Sequential increment wraps modulo 2^ADRS_W.
               pc_next_d  = branch_taken ? branch_target : mem_adrs_q + ADRS_W'(1);
            end
         end
         StSync: begin
            // Fetch resumes from pc_next, which the PC is loading this same cycle.
            if (fetch_en) begin
               state_d    = StReq;
               mem_adrs_d = pc_next_q;
               mem_req_d  = 1'b1;
               cnt_d      = '0;
            end else begin
               state_d = StIdle;
            end
         end
         StErr: begin
            mem_req_d  = 1'b0;
            ir_valid_d = 1'b0;
            err_d      = 1'b1;
         end
         default: begin
            state_d    = StIdle;
            mem_req_d  = 1'b0;
            ir_valid_d = 1'b0;
         end
      endcase
   end

   // State register with synchronous active-high clear.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q    <= StIdle;
         pc_next_q  <= '0;
         mem_adrs_q <= '0;
         ir_q       <= '0;
         cnt_q      <= '0;
         mem_req_q  <= 1'b0;
         en_pc_q    <= 1'b0;
         ir_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_next_q  <= pc_next_d;
         mem_adrs_q <= mem_adrs_d;
         ir_q       <= ir_d;
         cnt_q      <= cnt_d;
         mem_req_q  <= mem_req_d;
         en_pc_q    <= en_pc_d;
         ir_valid_q <= ir_valid_d;
         err_q      <= err_d;
      end
   end

   assign pc_next   = pc_next_q;
   assign en_pc     = en_pc_q;
   assign mem_req   = mem_req_q;
   assign mem_adrs  = mem_adrs_q;
   assign ir_out    = ir_q;
   assign ir_valid  = ir_valid_q;
   assign fetch_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        clr;
   logic        fetch_en;
   logic [7:0]  pc_adrs;
   logic [7:0]  pc_next;
   logic        en_pc;
   logic        mem_req;
   logic [7:0]  mem_adrs;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] ir_out;
   logic        ir_valid;
   logic        ir_ready;
   logic        branch_taken;
   logic [7:0]  branch_target;
   logic        fetch_err;

   int n_checks = 0;
   int n_errors = 0;

   fetch_unit dut (
      .clk          (clk),
      .clr          (clr),
      .fetch_en     (fetch_en),
      .pc_adrs      (pc_adrs),
      .pc_next      (pc_next),
      .en_pc        (en_pc),
      .mem_req      (mem_req),
      .mem_adrs     (mem_adrs),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .ir_out       (ir_out),
      .ir_valid     (ir_valid),
      .ir_ready     (ir_ready),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .fetch_err    (fetch_err)
   );

   always #5 clk = ~clk;

   // Instruction memory contents model.
   function automatic logic [15:0] mem_f(input logic [7:0] a);
      return {a ^ 8'hA5, ~a};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Starts in REQ at address a; completes one fetch with ir_ready=1 and ends one cycle after SYNC.
   task automatic fetch_one(input logic [7:0] a, input logic [7:0] nxt);
      check("req_high", mem_req, 1);
      check("req_adrs", mem_adrs, a);
      check("req_ivalid", ir_valid, 0);
      mem_ack   = 1'b1;
      mem_rdata = mem_f(a);
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 16'hDEAD;
      check("hold_ivalid", ir_valid, 1);
      check("hold_ir", ir_out, mem_f(a));
      check("hold_req", mem_req, 0);
      check("hold_enpc", en_pc, 0);
      tick();
      branch_taken = 1'b0;
      check("sync_enpc", en_pc, 1);
      check("sync_pcnext", pc_next, nxt);
      check("sync_ivalid", ir_valid, 0);
      tick();
      check("post_enpc", en_pc, 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_pcnext"}, pc_next, 0);
      check({tag, "_enpc"}, en_pc, 0);
      check({tag, "_req"}, mem_req, 0);
      check({tag, "_adrs"}, mem_adrs, 0);
      check({tag, "_ir"}, ir_out, 0);
      check({tag, "_ivalid"}, ir_valid, 0);
      check({tag, "_err"}, fetch_err, 0);
   endtask

   task automatic do_reset();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          n;
      logic [15:0] held;

      clr           = 1'b1;
      fetch_en      = 1'b0;
      pc_adrs       = 8'h00;
      mem_ack       = 1'b0;
      mem_rdata     = 16'h0;
      ir_ready      = 1'b1;
      branch_taken  = 1'b0;
      branch_target = 8'h00;
      tick();
      tick();
      check_all_zero("reset");

      // Sequential fetch 01..04.
      clr      = 1'b0;
      pc_adrs  = 8'h01;
      fetch_en = 1'b1;
      tick();
      fetch_one(8'h01, 8'h02);
      fetch_one(8'h02, 8'h03);
      fetch_one(8'h03, 8'h04);
      fetch_one(8'h04, 8'h05);
      check("seq_next_adrs", mem_adrs, 8'h05);

      // Wrap FF -> 00.
      do_reset();
      check("rst2_req", mem_req, 0);
      pc_adrs = 8'hFF;
      tick();
      fetch_one(8'hFF, 8'h00);
      check("wrap_adrs", mem_adrs, 8'h00);
      check("wrap_req", mem_req, 1);

      // Branch at 03 to 40; branch_taken held through REQ must not matter.
      do_reset();
      pc_adrs       = 8'h03;
      branch_taken  = 1'b1;
      branch_target = 8'h40;
      tick();
      fetch_one(8'h03, 8'h40);
      check("branch_adrs", mem_adrs, 8'h40);

      // Decoder stall at 40; stray mem_ack in HOLD ignored.
      ir_ready  = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = mem_f(8'h40);
      tick();
      held      = mem_f(8'h40);
      mem_rdata = 16'h1234;
      for (int i = 0; i < 5; i++) begin
         check("stall_ivalid", ir_valid, 1);
         check("stall_ir", ir_out, held);
         check("stall_enpc", en_pc, 0);
         check("stall_req", mem_req, 0);
         tick();
      end
      mem_ack  = 1'b0;
      ir_ready = 1'b1;
      fetch_en = 1'b0;
      tick();
      check("stall_enpc_pulse", en_pc, 1);
      check("stall_pcnext", pc_next, 8'h41);
      tick();
      check("park_enpc", en_pc, 0);
      check("park_req", mem_req, 0);
      tick();
      check("park_req2", mem_req, 0);

      // Timeout.
      pc_adrs  = 8'h10;
      fetch_en = 1'b1;
      tick();
      n = 0;
      while (mem_req === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      check("to_cycles", n, 15);
      check("to_err", fetch_err, 1);
      check("to_req", mem_req, 0);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      tick();
      tick();
      check("err_req", mem_req, 0);
      check("err_ivalid", ir_valid, 0);
      check("err_enpc", en_pc, 0);
      check("err_sticky", fetch_err, 1);
      fetch_en = 1'b0;
      do_reset();
      check_all_zero("err_clr");

      // Reset mid-REQ; late ack ignored.
      pc_adrs  = 8'h22;
      fetch_en = 1'b1;
      tick();
      check("mid_req", mem_req, 1);
      clr = 1'b1;
      tick();
      clr      = 1'b0;
      fetch_en = 1'b0;
      check("mid_clr_req", mem_req, 0);
      mem_ack   = 1'b1;
      mem_rdata = 16'hBEEF;
      tick();
      mem_ack = 1'b0;
      check("late_ack_ivalid", ir_valid, 0);
      check("late_ack_req", mem_req, 0);
      check("late_ack_ir", ir_out, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Consumer and driver of the program counter. Reads `pc` adrs_out, fetches the instruction at that address from instruction memory over a req/ack handshake, and holds it in an instruction register for the decoder.
- Returns the next address to `pc` adrs_in, either sequential or a branch target, together with the en_pc load strobe.
- Sits between `pc`, instruction memory and the decode stage of s_proc.

Parameters:
- ADRS_W, 8, address width; matches `pc` adrs_in/adrs_out.
- INSTR_W, 16, instruction word width.
- TIMEOUT, 15, max cycles in REQ without mem_ack before a fetch error.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- clr  in  1  synchronous, active-high reset.
- fetch_en  in  1  run enable; start or continue fetching.
- pc_adrs  in  ADRS_W  current PC value (from `pc` adrs_out).
- pc_next  out  ADRS_W  next PC value (to `pc` adrs_in).
- en_pc  out  1  one-cycle PC load strobe (to `pc` en_pc).
- mem_req  out  1  instruction memory read request.
- mem_adrs  out  ADRS_W  read address; stable while mem_req=1.
- mem_ack  in  1  memory read done; mem_rdata valid in the same cycle.
- mem_rdata  in  INSTR_W  instruction read data.
- ir_out  out  INSTR_W  latched instruction.
- ir_valid  out  1  ir_out holds an unconsumed instruction.
- ir_ready  in  1  decoder accepts ir_out.
- branch_taken  in  1  decoder requests a redirect; sampled only on handshake.
- branch_target  in  ADRS_W  redirect address.
- fetch_err  out  1  sticky memory timeout flag.

Behaviour:
- All outputs are registered. While clr=1 at a posedge: state=IDLE; pc_next, mem_adrs, ir_out, wait counter = 0; mem_req, en_pc, ir_valid, fetch_err = 0.
- clr overrides everything, including mid-REQ. An outstanding mem_ack after reset is ignored.
- FSM states: IDLE, REQ, HOLD, SYNC, ERR.
- IDLE:
  - fetch_en=1 -> REQ.
  - On entry to REQ: mem_adrs<=pc_adrs, mem_req<=1, counter<=0.
- REQ:
  - mem_req=1 and mem_adrs held stable.
  - mem_ack=1 -> ir_out<=mem_rdata, ir_valid<=1, mem_req<=0, -> HOLD. An ack in the first REQ cycle is legal.
  - Otherwise counter increments. When counter=TIMEOUT with no ack -> fetch_err<=1, mem_req<=0, -> ERR.
- HOLD:
  - ir_valid=1, ir_out stable.
  - ir_valid and ir_ready at a posedge -> ir_valid<=0, en_pc<=1, -> SYNC.
  - pc_next<=branch_taken ? branch_target : mem_adrs+1. Sequential increment is modulo 2^ADRS_W (8'hFF -> 8'h00).
- SYNC:
  - Lasts one cycle; en_pc=1 for exactly this cycle, and `pc` loads pc_next at the end of it.
  - Next: en_pc<=0. If fetch_en=1 -> REQ with mem_adrs<=pc_next; else -> IDLE.
- ERR: all strobes 0, fetch_err=1; leaves only via clr.
- fetch_en=0 mid-fetch: the current REQ/HOLD/SYNC completes; the unit parks in IDLE after SYNC. No fetch is abandoned.
- mem_ack outside REQ is ignored. branch_taken outside a HOLD handshake is ignored.
- Latency:
  - REQ entry -> ir_valid: one cycle after mem_ack.
  - Handshake -> en_pc: 1 cycle.
  - Handshake -> next mem_req: 2 cycles.
- Invariant: en_pc never asserts in consecutive cycles. mem_req and ir_valid are never both 1.

Decomposition:
- Shared package s_proc_pkg:
  - ADRS_W and INSTR_W defaults.
  - FSM state encoding localparams: IDLE=0, REQ=1, HOLD=2, SYNC=3, ERR=4 (3 bits).
- Single flat module. The wait counter is inline; no sub-module is warranted.

Test Plan:
- Sequential fetch: clr 1->0, pc_adrs=8'h01, fetch_en=1, mem_ack one cycle after each req, ir_ready=1 -> mem_adrs 01,02,03,04; pc_next 02,03,04,05; ir_out equals the memory model contents.
- Wrap: start pc_adrs=8'hFF -> after handshake pc_next=8'h00, next mem_adrs=8'h00.
- Branch: ir handshake with branch_taken=1, branch_target=8'h40 at address 8'h03 -> pc_next=8'h40, en_pc 1-cycle pulse, next mem_adrs=8'h40.
- Decoder stall: ir_ready=0 for 5 cycles -> ir_valid and ir_out stable, en_pc=0, mem_req=0; ir_ready=1 -> en_pc pulse next cycle.
- Timeout: mem_ack held 0 -> fetch_err=1 after 15 REQ cycles, mem_req=0, no further activity until clr; clr -> all outputs 0.
- Reset mid-REQ: assert clr while mem_req=1 -> next cycle state IDLE, mem_req=0. A late mem_ack is ignored and ir_valid stays 0.
